// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
//   MUL_WIDTH      operand width (fixed by the 32-bit Add instance)
//   MUL_CNT_W      iteration counter width
//   MUL_LAST_ITER  counter value at which the final iteration runs
//   mul_state_e    controller state encoding (IDLE/RUN/DONE)
package mul_seq_pkg;

  localparam int unsigned MUL_WIDTH     = 32;
  localparam int unsigned MUL_CNT_W     = 6;
  localparam int unsigned MUL_LAST_ITER = 31;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_seq_add_if.sv
// Operand/result handshake bundle for mul_seq_add.
//   in_valid/in_ready/a/b        operand channel (master -> slave)
//   out_valid/out_ready/product  result channel (slave -> master)
//   busy                         iteration in progress (slave -> master)
// The multiplier uses the slave modport; the upstream stage uses master.
interface mul_seq_add_if;
  import mul_seq_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [MUL_WIDTH-1:0]     a;
  logic [MUL_WIDTH-1:0]     b;
  logic                     out_valid;
  logic                     out_ready;
  logic [2*MUL_WIDTH-1:0]   product;
  logic                     busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );

endinterface

// File: rtl/Add.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
//   a, b  addends
//   sum   a + b modulo 2^32 (carry-out is not provided)
module Add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    logic gcar;
    logic grp_g;
    logic grp_p;
    c     = '0;
    gcar  = 1'b0;
    grp_g = 1'b0;
    grp_p = 1'b0;
    for (int j = 0; j < 8; j++) begin
      c[4*j]   = gcar;
      c[4*j+1] = g[4*j] | (p[4*j] & gcar);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gcar);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gcar);
      grp_g    = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      grp_p    = &p[4*j +: 4];
      gcar     = grp_g | (grp_p & gcar);
    end
  end

  assign sum = p ^ c;

endmodule

// File: rtl/mul_seq_add.sv
// Iterative 32x32 -> 64-bit unsigned shift-add multiplier.
// One partial-product step per cycle through a single shared Add instance.
//   clk         rising-edge clock
//   rst         synchronous active-high reset; aborts any operation in flight
//   bus         mul_seq_add_if.slave: in_valid/in_ready/a/b operand channel,
//               out_valid/out_ready/product result channel, busy status
//   perf_ops    (MUL_SEQ_PERF_CNT_EN only) completed result handshakes, saturating
//   perf_stall  (MUL_SEQ_PERF_CNT_EN only) DONE cycles with out_ready low, saturating
// Optional feature macro: MUL_SEQ_PERF_CNT_EN.
module mul_seq_add
  import mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH,
  parameter int unsigned CNT_W = MUL_CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  mul_seq_add_if.slave  bus
`ifdef MUL_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]   perf_ops,
  output logic [31:0]   perf_stall
`endif
);

  localparam logic [1:0] IDLE = MUL_IDLE;
  localparam logic [1:0] RUN  = MUL_RUN;
  localparam logic [1:0] DONE = MUL_DONE;

  if (WIDTH != MUL_WIDTH) begin : g_width_chk
    $error("mul_seq_add: WIDTH must be 32 to match the Add instance");
  end
  if ((2 ** CNT_W) <= WIDTH) begin : g_cnt_chk
    $error("mul_seq_add: CNT_W too narrow to hold WIDTH");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             out_fire;

  assign add_b = lo_q[0] ? mcand_q : '0;

  Add u_add (
    .a   (hi_q),
    .b   (add_b),
    .sum (sum)
  );

  // Add has no carry-out; recover it from the MSB operands and the MSB of the sum.
  assign co = (hi_q[WIDTH-1] & add_b[WIDTH-1])
            | ((hi_q[WIDTH-1] ^ add_b[WIDTH-1]) & ~sum[WIDTH-1]);

  assign out_fire = (state_q == DONE) & bus.out_ready;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_d = bus.a;
          lo_d    = bus.b;
          hi_d    = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // 33-bit partial sum shifts down one place; multiplier bits retire from lo.
        {hi_d, lo_d} = {co, sum, lo_q[WIDTH-1:1]};
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_LAST_ITER)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == RUN);
  assign bus.out_valid = (state_q == DONE);
  assign bus.product   = (state_q == DONE) ? {hi_q, lo_q} : '0;

`ifdef MUL_SEQ_PERF_CNT_EN
  logic [31:0] perf_ops_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (out_fire && (perf_ops_q != '1)) begin
        perf_ops_q <= perf_ops_q + 32'd1;
      end
      if ((state_q == DONE) && !bus.out_ready && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`else
  logic unused_out_fire;
  assign unused_out_fire = out_fire;
`endif

endmodule
